dmem_mio_bridge: RTL and testbench

- Data-side memory and I/O block directly downstream of the CPU MEM stage; consumes `Addr_out`, `Data_out`, `mem_w` and `dm_ctrl`, and returns load data on the CPU `Data_in` bus in the same cycle.
- Contains a word-organised data RAM with byte-lane stores and a small MMIO window: LED register, switch input, free-running cycle counter, one-shot countdown timer.
- Load data is returned fully aligned and sign/zero-extended; the CPU passes it straight to MEM/WB.
- The timer interrupt drives the CPU `INT` input.

---
 rtl/dmem_mio_bridge_pkg.sv | 43 ++++
 rtl/dmem_mio_bridge_mio_timer.sv | 42 ++++
 rtl/dmem_mio_bridge.sv | 176 +++++++++++++++++
 tb/tb_dmem_mio_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mio_bridge_pkg.sv
// Shared constants for the data-memory / MMIO bridge: access-type codes,
// MMIO register offsets and the default MMIO window base.
package dmem_mio_bridge_pkg;

   // CPU dm_ctrl access-type codes
   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF_S = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE_S = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   // MMIO register offsets inside the 256-byte window
   localparam logic [7:0] MIO_LED        = 8'h00;
   localparam logic [7:0] MIO_SW         = 8'h04;
   localparam logic [7:0] MIO_CYCLE      = 8'h08;
   localparam logic [7:0] MIO_TIMER_CNT  = 8'h0C;
   localparam logic [7:0] MIO_TIMER_STAT = 8'h10;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;

   // Count value at which the next decrement expires the timer
   localparam logic [31:0] TIMER_TC = 32'd1;

   typedef enum logic [1:0] {
      ACC_WORD = 2'd0,
      ACC_HALF = 2'd1,
      ACC_BYTE = 2'd2
   } acc_size_e;

   // Access width from dm_ctrl; unused codes behave as word accesses.
   function automatic acc_size_e dm_size(input logic [2:0] dm);
      case (dm)
         DM_HALF_S, DM_HALF_U: dm_size = ACC_HALF;
         DM_BYTE_S, DM_BYTE_U: dm_size = ACC_BYTE;
         default:              dm_size = ACC_WORD;
      endcase
   endfunction

   function automatic logic dm_signed(input logic [2:0] dm);
      dm_signed = (dm == DM_HALF_S) || (dm == DM_BYTE_S);
   endfunction

endpackage

// File: rtl/dmem_mio_bridge_mio_timer.sv
// Free-running cycle counter plus one-shot countdown timer with a sticky
// interrupt. Expiry (1->0) takes priority over a status-clear write.
module mio_timer
   import dmem_mio_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cnt_we,
   input  logic [31:0] cnt_wdata,
   input  logic        stat_we,
   output logic [31:0] cycle,
   output logic [31:0] count,
   output logic        irq
);

   logic [31:0] cycle_q;
   logic        expire;

   assign cycle  = cycle_q;
   assign expire = (count == TIMER_TC);

   // Cycle counter: zero in the reset cycle, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) cycle_q <= '0;
      else       cycle_q <= cycle_q + 32'd1;
   end

   // Countdown: a write reloads, otherwise decrement until zero (zero = idle).
   always_ff @(posedge clk) begin
      if (reset)              count <= '0;
      else if (cnt_we)        count <= cnt_wdata;
      else if (count != '0)   count <= count - 32'd1;
   end

   // Sticky interrupt: set on expiry even if cleared or reloaded that cycle.
   always_ff @(posedge clk) begin
      if (reset)        irq <= 1'b0;
      else if (expire)  irq <= 1'b1;
      else if (stat_we) irq <= 1'b0;
   end

endmodule

// File: rtl/dmem_mio_bridge.sv
// Data-side memory and MMIO block behind the CPU MEM stage. Word-organised
// RAM with byte-lane stores, combinational aligned/extended loads, and a
// small MMIO window (LED, switches, cycle counter, countdown timer).
module dmem_mio_bridge
   import dmem_mio_bridge_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   parameter int unsigned LED_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_w,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic [2:0]       dm_ctrl,
   output logic [31:0]      rdata,
   input  logic [LED_W-1:0] sw_in,
   output logic [LED_W-1:0] led_out,
   output logic             timer_irq,
   output logic             misalign_err
);

   localparam int AW = $clog2(RAM_WORDS);

   logic [31:0]      ram [RAM_WORDS];

   acc_size_e        acc_size;
   logic             acc_signed;
   logic             misaligned;
   logic             ram_hit;
   logic             mmio_hit;
   logic             mmio_word;
   logic [AW-1:0]    ram_idx;
   logic [7:0]       mio_off;

   logic [3:0]       lane_en;
   logic [31:0]      lane_data;
   logic             ram_we;
   logic             led_we;
   logic             cnt_we;
   logic             stat_we;

   logic [31:0]      ram_word;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      ram_load;
   logic [31:0]      mmio_load;

   logic [31:0]      led_q;
   logic [LED_W-1:0] sw_q1;
   logic [LED_W-1:0] sw_q2;
   logic [31:0]      cycle_cnt;
   logic [31:0]      timer_cnt;

   // Address decode and alignment check for the current access.
   always_comb begin
      acc_size   = dm_size(dm_ctrl);
      acc_signed = dm_signed(dm_ctrl);
      misaligned = ((acc_size == ACC_HALF) && addr[0]) ||
                   ((acc_size == ACC_WORD) && (addr[1:0] != 2'b00));
      ram_hit    = (addr[31:AW+2] == '0);
      mmio_hit   = (addr[31:8] == MMIO_BASE[31:8]);
      // MMIO registers only respond to aligned word accesses.
      mmio_word  = mmio_hit && (acc_size == ACC_WORD) && !misaligned;
      ram_idx    = addr[AW+1:2];
      mio_off    = addr[7:0];
   end

   // Store lane enables and lane-replicated store data.
   always_comb begin
      case (acc_size)
         ACC_BYTE: begin
            lane_en   = 4'b0001 << addr[1:0];
            lane_data = {4{wdata[7:0]}};
         end
         ACC_HALF: begin
            lane_en   = addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
         end
         default: begin
            lane_en   = 4'b1111;
            lane_data = wdata;
         end
      endcase
   end

   // Write strobes; a store coinciding with reset is dropped.
   always_comb begin
      ram_we  = mem_w && ram_hit && !misaligned && !reset;
      led_we  = mem_w && mmio_word && (mio_off == MIO_LED);
      cnt_we  = mem_w && mmio_word && (mio_off == MIO_TIMER_CNT);
      stat_we = mem_w && mmio_word && (mio_off == MIO_TIMER_STAT);
   end

   // Byte-lane RAM write; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) ram[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   // RAM load path: pick the lane(s), right-align, then extend.
   always_comb begin
      ram_word = ram[ram_idx];
      byte_sel = ram_word[{addr[1:0], 3'b000} +: 8];
      half_sel = ram_word[{addr[1], 4'b0000} +: 16];
      case (acc_size)
         ACC_BYTE: ram_load = acc_signed ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'b0, byte_sel};
         ACC_HALF: ram_load = acc_signed ? {{16{half_sel[15]}}, half_sel}
                                         : {16'b0, half_sel};
         default:  ram_load = ram_word;
      endcase
   end

   // MMIO read mux; unlisted offsets read as zero.
   always_comb begin
      mmio_load = '0;
      case (mio_off)
         MIO_LED:        mmio_load = led_q;
         MIO_SW:         mmio_load[LED_W-1:0] = sw_q2;
         MIO_CYCLE:      mmio_load = cycle_cnt;
         MIO_TIMER_CNT:  mmio_load = timer_cnt;
         MIO_TIMER_STAT: mmio_load = {31'b0, timer_irq};
         default:        ;
      endcase
   end

   // Final load data; misaligned and unmapped accesses return zero.
   always_comb begin
      if (misaligned)     rdata = '0;
      else if (ram_hit)   rdata = ram_load;
      else if (mmio_word) rdata = mmio_load;
      else                rdata = '0;
   end

   // LED register.
   always_ff @(posedge clk) begin
      if (reset)       led_q <= '0;
      else if (led_we) led_q <= wdata;
   end

   assign led_out = led_q[LED_W-1:0];

   // Two-flop synchroniser for the asynchronous board switches.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_q1 <= '0;
         sw_q2 <= '0;
      end else begin
         sw_q1 <= sw_in;
         sw_q2 <= sw_q1;
      end
   end

   // Sticky misaligned-access flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)           misalign_err <= 1'b0;
      else if (misaligned) misalign_err <= 1'b1;
   end

   mio_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .cnt_we    (cnt_we),
      .cnt_wdata (wdata),
      .stat_we   (stat_we),
      .cycle     (cycle_cnt),
      .count     (timer_cnt),
      .irq       (timer_irq)
   );

endmodule

// File: tb/tb_dmem_mio_bridge.sv
// Self-checking bench for dmem_mio_bridge: directed scenarios followed by a
// randomized phase, all compared against a byte-array / register model.
module tb_dmem_mio_bridge;
   import dmem_mio_bridge_pkg::*;

   localparam logic [31:0] MB        = 32'hF000_0000;
   localparam int          RAM_BYTES = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  dm_ctrl;
   logic [31:0] rdata;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic        timer_irq;
   logic        misalign_err;

   dmem_mio_bridge #(
      .RAM_WORDS (1024),
      .MMIO_BASE (MB),
      .LED_W     (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_w        (mem_w),
      .addr         (addr),
      .wdata        (wdata),
      .dm_ctrl      (dm_ctrl),
      .rdata        (rdata),
      .sw_in        (sw_in),
      .led_out      (led_out),
      .timer_irq    (timer_irq),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [7:0]  ref_mem   [RAM_BYTES];
   bit          ref_known [RAM_BYTES];
   logic [31:0] m_led, m_cnt, m_cycle;
   logic        m_irq, m_err;
   logic [15:0] m_s1, m_s2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int acc_bytes(input logic [2:0] c);
      if (c == DM_HALF_S || c == DM_HALF_U) return 2;
      if (c == DM_BYTE_S || c == DM_BYTE_U) return 1;
      return 4;
   endfunction

   // Natural alignment: address must be a multiple of the access size.
   function automatic bit is_mis(input logic [31:0] a, input logic [2:0] c);
      return (a % 32'(acc_bytes(c))) != 32'd0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c,
                                            output bit known);
      int          n;
      logic [31:0] v;
      n     = acc_bytes(c);
      v     = '0;
      known = 1'b1;
      if (is_mis(a, c)) return '0;
      if (a < RAM_BYTES) begin
         for (int i = 0; i < n; i++) begin
            v = v | (32'(ref_mem[12'(a) + 12'(i)]) << (8 * i));
            if (!ref_known[12'(a) + 12'(i)]) known = 1'b0;
         end
         if (c == DM_HALF_S && v[15]) v = v | 32'hFFFF_0000;
         if (c == DM_BYTE_S && v[7])  v = v | 32'hFFFF_FF00;
         return v;
      end
      if (a[31:8] == MB[31:8] && n == 4) begin
         case (a[7:0])
            8'h00:   return m_led;
            8'h04:   return {16'b0, m_s2};
            8'h08:   return m_cycle;
            8'h0C:   return m_cnt;
            8'h10:   return {31'b0, m_irq};
            default: return '0;
         endcase
      end
      return '0;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int   n;
      bit   mis, cnt_wr, clr, expire;
      if (reset) begin
         m_led = '0; m_cnt = '0; m_cycle = '0; m_irq = 1'b0; m_err = 1'b0;
         m_s1 = '0; m_s2 = '0;
         return;
      end
      n      = acc_bytes(dm_ctrl);
      mis    = is_mis(addr, dm_ctrl);
      expire = (m_cnt == 32'd1);
      cnt_wr = 1'b0;
      clr    = 1'b0;
      if (mis) m_err = 1'b1;
      if (mem_w && !mis) begin
         if (addr < RAM_BYTES) begin
            for (int i = 0; i < n; i++) begin
               ref_mem[12'(addr) + 12'(i)]   = wdata[8*i +: 8];
               ref_known[12'(addr) + 12'(i)] = 1'b1;
            end
         end else if (addr[31:8] == MB[31:8] && n == 4) begin
            case (addr[7:0])
               8'h00:   m_led = wdata;
               8'h0C:   cnt_wr = 1'b1;
               8'h10:   clr = 1'b1;
               default: ;
            endcase
         end
      end
      if (cnt_wr)          m_cnt = wdata;
      else if (m_cnt != 0) m_cnt = m_cnt - 32'd1;
      if (expire)   m_irq = 1'b1;
      else if (clr) m_irq = 1'b0;
      m_cycle = m_cycle + 32'd1;
      m_s2 = m_s1;
      m_s1 = sw_in;
   endtask

   // Drive one access and compare all outputs against the model.
   task automatic put(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c);
      bit          known;
      logic [31:0] e;
      mem_w = w; addr = a; wdata = d; dm_ctrl = c;
      #1;
      e = ref_load(a, c, known);
      if (known) chk("rdata", rdata, e);
      chk("led", {16'b0, led_out}, {16'b0, m_led[15:0]});
      chk("irq", {31'b0, timer_irq}, {31'b0, m_irq});
      chk("err", {31'b0, misalign_err}, {31'b0, m_err});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      put(1'b0, MB + 32'h08, 32'h0, DM_WORD);
   endtask

   initial begin
      reset = 1'b1; mem_w = 1'b0; addr = MB + 32'h08; wdata = '0; dm_ctrl = DM_WORD;
      sw_in = '0;
      m_led = '0; m_cnt = '0; m_cycle = '0; m_irq = 1'b0; m_err = 1'b0;
      m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < RAM_BYTES; i++) ref_known[i] = 1'b0;

      tick(); tick();
      // reset state and cycle counter start
      idle();
      chk("rst_cycle", rdata, 32'd0);
      chk("rst_led", {16'b0, led_out}, 32'd0);
      chk("rst_irq", {31'b0, timer_irq}, 32'd0);
      chk("rst_err", {31'b0, misalign_err}, 32'd0);
      reset = 1'b0;
      tick(); idle(); chk("cycle1", rdata, 32'd1);
      tick(); idle(); chk("cycle2", rdata, 32'd2);
      tick();

      // fill RAM so later loads have defined contents
      for (int w = 0; w < 1024; w++) begin
         put(1'b1, 32'(w * 4), $urandom, DM_WORD);
         tick();
      end

      // lane stores and extended loads
      put(1'b1, 32'h40, 32'h1122_3344, DM_WORD);   tick();
      put(1'b1, 32'h41, 32'h0000_00AA, DM_BYTE_U); tick();
      put(1'b0, 32'h40, 32'h0, DM_WORD);   chk("lw40", rdata, 32'h1122_AA44); tick();
      put(1'b0, 32'h41, 32'h0, DM_BYTE_S); chk("lb41", rdata, 32'hFFFF_FFAA); tick();
      put(1'b0, 32'h41, 32'h0, DM_BYTE_U); chk("lbu41", rdata, 32'h0000_00AA); tick();
      put(1'b1, 32'h42, 32'h0000_8001, DM_HALF_S); tick();
      put(1'b0, 32'h42, 32'h0, DM_HALF_S); chk("lh42", rdata, 32'hFFFF_8001); tick();
      put(1'b0, 32'h42, 32'h0, DM_HALF_U); chk("lhu42", rdata, 32'h0000_8001); tick();
      put(1'b0, 32'h40, 32'h0, DM_WORD);   chk("lw40b", rdata, 32'h8001_AA44); tick();
      put(1'b1, 32'h40, 32'hCAFE_F00D, DM_WORD); chk("st_same", rdata, 32'h8001_AA44); tick();
      put(1'b0, 32'h40, 32'h0, DM_WORD);   chk("st_next", rdata, 32'hCAFE_F00D); tick();

      // MMIO LED, byte store ignored, switch synchroniser lag
      put(1'b1, MB, 32'h0000_BEEF, DM_WORD); tick();
      idle(); chk("led_beef", {16'b0, led_out}, 32'h0000_BEEF); tick();
      put(1'b1, MB, 32'h0000_0012, DM_BYTE_U); tick();
      put(1'b0, MB, 32'h0, DM_WORD);   chk("led_keep", rdata, 32'h0000_BEEF); tick();
      put(1'b0, MB, 32'h0, DM_HALF_U); chk("mmio_half", rdata, 32'h0); tick();
      sw_in = 16'h5A5A;
      put(1'b0, MB + 32'h04, 32'h0, DM_WORD); chk("sw_lag0", rdata, 32'h0); tick();
      put(1'b0, MB + 32'h04, 32'h0, DM_WORD); chk("sw_lag1", rdata, 32'h0); tick();
      put(1'b0, MB + 32'h04, 32'h0, DM_WORD); chk("sw_lag2", rdata, 32'h0000_5A5A); tick();
      put(1'b1, MB + 32'h08, 32'h0, DM_WORD); tick();
      idle(); tick();
      put(1'b1, 32'h0001_0000, 32'h1, DM_WORD); tick();
      put(1'b0, 32'h0001_0000, 32'h0, DM_WORD); chk("unmapped", rdata, 32'h0); tick();

      // timer expiry, clear, and same-cycle priorities
      put(1'b1, MB + 32'h0C, 32'd3, DM_WORD); tick();
      put(1'b0, MB + 32'h0C, 32'h0, DM_WORD); chk("cnt3", rdata, 32'd3);
      chk("irq_e0", {31'b0, timer_irq}, 32'd0); tick();
      idle(); chk("irq_e1", {31'b0, timer_irq}, 32'd0); tick();
      idle(); chk("irq_e2", {31'b0, timer_irq}, 32'd0); tick();
      put(1'b0, MB + 32'h10, 32'h0, DM_WORD);
      chk("irq_e3", {31'b0, timer_irq}, 32'd1); chk("stat_rd", rdata, 32'd1); tick();
      put(1'b1, MB + 32'h10, 32'h0, DM_WORD); tick();
      put(1'b0, MB + 32'h10, 32'h0, DM_WORD);
      chk("irq_clr", {31'b0, timer_irq}, 32'd0); chk("stat_clr", rdata, 32'd0); tick();
      put(1'b1, MB + 32'h0C, 32'd2, DM_WORD); tick();
      idle(); tick();
      put(1'b1, MB + 32'h10, 32'h0, DM_WORD); tick();
      idle(); chk("set_wins", {31'b0, timer_irq}, 32'd1); tick();
      put(1'b1, MB + 32'h10, 32'h0, DM_WORD); tick();
      put(1'b1, MB + 32'h0C, 32'd1, DM_WORD); tick();
      put(1'b1, MB + 32'h0C, 32'd5, DM_WORD); tick();
      put(1'b0, MB + 32'h0C, 32'h0, DM_WORD);
      chk("wr_exp_irq", {31'b0, timer_irq}, 32'd1); chk("wr_exp_cnt", rdata, 32'd5); tick();
      put(1'b1, MB + 32'h10, 32'h0, DM_WORD); tick();
      put(1'b1, MB + 32'h0C, 32'd4, DM_WORD); tick();
      put(1'b1, MB + 32'h0C, 32'd0, DM_WORD); tick();
      for (int i = 0; i < 6; i++) begin idle(); tick(); end
      put(1'b0, MB + 32'h0C, 32'h0, DM_WORD);
      chk("dis_cnt", rdata, 32'd0); chk("dis_irq", {31'b0, timer_irq}, 32'd0); tick();

      // misalignment: store suppressed, sticky flag
      put(1'b1, 32'h44, 32'h5566_7788, DM_WORD); tick();
      put(1'b1, 32'h45, 32'hDEAD_BEEF, DM_WORD);
      chk("mis_rd", rdata, 32'h0); chk("err_pre", {31'b0, misalign_err}, 32'd0); tick();
      put(1'b0, 32'h44, 32'h0, DM_WORD);
      chk("mis_nowr", rdata, 32'h5566_7788); chk("err_set", {31'b0, misalign_err}, 32'd1); tick();
      put(1'b0, 32'h43, 32'h0, DM_HALF_U); chk("mis_half", rdata, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin idle(); tick(); end
      idle(); chk("err_sticky", {31'b0, misalign_err}, 32'd1); tick();

      // reset mid-operation with a running timer and a concurrent store
      put(1'b1, 32'h48, 32'h0102_0304, DM_WORD); tick();
      put(1'b1, MB + 32'h0C, 32'd10, DM_WORD); tick();
      reset = 1'b1;
      put(1'b1, 32'h48, 32'hFFFF_FFFF, DM_WORD); tick();
      reset = 1'b0;
      put(1'b0, 32'h48, 32'h0, DM_WORD);
      chk("rst_store", rdata, 32'h0102_0304);
      chk("rst_err2", {31'b0, misalign_err}, 32'd0);
      chk("rst_led2", {16'b0, led_out}, 32'd0); tick();
      put(1'b0, MB + 32'h0C, 32'h0, DM_WORD); chk("rst_cnt", rdata, 32'd0); tick();

      // cycle counter wrap from a forced all-ones value
      force dut.u_timer.cycle_q = 32'hFFFF_FFFF;
      m_cycle = 32'hFFFF_FFFF;
      idle(); chk("cyc_ff", rdata, 32'hFFFF_FFFF);
      release dut.u_timer.cycle_q;
      tick();
      idle(); chk("cyc_wrap", rdata, 32'd0); tick();
      idle(); chk("cyc_wrap1", rdata, 32'd1); tick();

      // randomized mix of RAM, MMIO and unmapped accesses
      for (int k = 0; k < 400; k++) begin
         int          kind;
         logic [31:0] a, d;
         logic [2:0]  c;
         logic        w;
         kind  = int'($urandom_range(0, 9));
         c     = 3'($urandom_range(0, 7));
         w     = 1'($urandom_range(0, 1));
         d     = $urandom;
         sw_in = 16'($urandom);
         if (kind < 6) begin
            a = 32'($urandom_range(0, RAM_BYTES - 1));
         end else if (kind < 9) begin
            a = MB + 32'(4 * $urandom_range(0, 5));
            if ($urandom_range(0, 3) != 0) c = DM_WORD;
            if (a == MB + 32'h0C) d = 32'($urandom_range(0, 6));
         end else begin
            a = 32'h0001_0000 + 32'(4 * $urandom_range(0, 255));
         end
         put(w, a, d, c);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
